// File: rtl/prgrom_upg_ctrl.sv
// UART program-ROM upgrade sequencer: header(N) + N little-endian words -> ROM write port.
// Define LOAD_CHECKSUM_EN to require a trailing XOR checksum byte before the ROM is handed back.
module prgrom_upg_ctrl #(
  parameter int ADDR_W         = 14,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              prog_req_i,
  input  logic              rx_valid_i,
  input  logic [7:0]        rx_data_i,
  output logic              upg_rst_o,
  output logic              upg_wen_o,
  output logic [ADDR_W-1:0] upg_adr_o,
  output logic [31:0]       upg_dat_o,
  output logic              upg_done_o,
  output logic              cpu_rst_n_o,
  output logic              busy_o,
  output logic              err_o,
  output logic [2:0]        state_o
);

  // Byte handshake: rx_valid_i is a one-cycle strobe with no back-pressure; every
  // strobe seen in HDR0/HDR1/DATA/WRITE(/CHK) is consumed on that rising edge.
  localparam int unsigned          MAX_N    = 2 ** ADDR_W;
  localparam int                   CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]     TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

`ifdef LOAD_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_HDR0, S_HDR1, S_DATA, S_WRITE, S_DONE, S_ERR, S_CHK
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_HDR0, S_HDR1, S_DATA, S_WRITE, S_DONE, S_ERR
  } state_t;
`endif

  state_t              state_q, state_d;
  logic [15:0]         n_q;
  logic [23:0]         asm_q;
  logic [1:0]          byte_idx_q;
  logic [ADDR_W-1:0]   word_idx_q;
  logic [CNT_W-1:0]    tmo_q;
  logic [15:0]         n_full;
  logic                bad_n, last_word, tmo_hit, counting;

  assign n_full    = {rx_data_i, n_q[7:0]};
  assign bad_n     = (n_full == 16'd0) || (32'(n_full) > MAX_N);
  assign last_word = (32'(word_idx_q) + 32'd1) == 32'(n_q);
  assign tmo_hit   = (tmo_q == TMO_LAST);
  assign state_o   = state_q;

`ifdef LOAD_CHECKSUM_EN
  logic [7:0] xor_q;
  logic       chk_ok;
  assign chk_ok   = (rx_data_i == xor_q);
  assign counting = (state_q == S_HDR0) || (state_q == S_HDR1) ||
                    (state_q == S_DATA) || (state_q == S_CHK);
`else
  assign counting = (state_q == S_HDR0) || (state_q == S_HDR1) || (state_q == S_DATA);
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: if (prog_req_i) state_d = S_HDR0;
      S_HDR0: begin
        if (rx_valid_i)   state_d = S_HDR1;
        else if (tmo_hit) state_d = S_ERR;
      end
      S_HDR1: begin
        if (rx_valid_i)   state_d = bad_n ? S_ERR : S_DATA;
        else if (tmo_hit) state_d = S_ERR;
      end
      S_DATA: begin
        if (rx_valid_i) begin
          if (byte_idx_q == 2'd3) state_d = S_WRITE;
        end else if (tmo_hit) begin
          state_d = S_ERR;
        end
      end
      S_WRITE: begin
        if (!last_word) begin
          state_d = S_DATA;
        end else begin
`ifdef LOAD_CHECKSUM_EN
          // A checksum byte can arrive back-to-back during the final write.
          if (rx_valid_i) state_d = chk_ok ? S_DONE : S_ERR;
          else            state_d = S_CHK;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef LOAD_CHECKSUM_EN
      S_CHK: begin
        if (rx_valid_i)   state_d = chk_ok ? S_DONE : S_ERR;
        else if (tmo_hit) state_d = S_ERR;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      upg_rst_o   <= 1'b1;
      upg_wen_o   <= 1'b0;
      upg_adr_o   <= '0;
      upg_dat_o   <= '0;
      upg_done_o  <= 1'b0;
      cpu_rst_n_o <= 1'b1;
      busy_o      <= 1'b0;
      err_o       <= 1'b0;
      n_q         <= '0;
      asm_q       <= '0;
      byte_idx_q  <= '0;
      word_idx_q  <= '0;
      tmo_q       <= '0;
`ifdef LOAD_CHECKSUM_EN
      xor_q       <= '0;
`endif
    end else begin
      state_q   <= state_d;
      upg_wen_o <= (state_d == S_WRITE);

      if ((state_d != state_q) || rx_valid_i) tmo_q <= '0;
      else if (counting)                      tmo_q <= tmo_q + CNT_W'(1);

      case (state_q)
        S_HDR0: if (rx_valid_i) n_q[7:0] <= rx_data_i;
        S_HDR1: begin
          if (rx_valid_i) begin
            n_q[15:8]  <= rx_data_i;
            byte_idx_q <= '0;
            word_idx_q <= '0;
`ifdef LOAD_CHECKSUM_EN
            xor_q      <= '0;
`endif
          end
        end
        S_DATA: begin
          if (rx_valid_i) begin
            byte_idx_q <= byte_idx_q + 2'd1;
`ifdef LOAD_CHECKSUM_EN
            xor_q      <= xor_q ^ rx_data_i;
`endif
            case (byte_idx_q)
              2'd0: asm_q[7:0]   <= rx_data_i;
              2'd1: asm_q[15:8]  <= rx_data_i;
              2'd2: asm_q[23:16] <= rx_data_i;
              default: begin
                upg_dat_o <= {rx_data_i, asm_q};
                upg_adr_o <= word_idx_q;
              end
            endcase
          end
        end
        S_WRITE: begin
          if (!last_word) begin
            word_idx_q <= word_idx_q + ADDR_W'(1);
            if (rx_valid_i) begin
              asm_q[7:0] <= rx_data_i;
              byte_idx_q <= 2'd1;
`ifdef LOAD_CHECKSUM_EN
              xor_q      <= xor_q ^ rx_data_i;
`endif
            end
          end
        end
        default: ;
      endcase

      if (state_d != state_q) begin
        case (state_d)
          S_HDR0: begin
            upg_rst_o   <= 1'b0;
            cpu_rst_n_o <= 1'b0;
            busy_o      <= 1'b1;
            err_o       <= 1'b0;
            upg_done_o  <= 1'b0;
          end
          S_DONE: begin
            upg_done_o  <= 1'b1;
            upg_rst_o   <= 1'b0;
            cpu_rst_n_o <= 1'b1;
            busy_o      <= 1'b0;
          end
          S_ERR: begin
            // CPU stays in reset: the ROM image is partial.
            err_o       <= 1'b1;
            upg_rst_o   <= 1'b1;
            upg_done_o  <= 1'b0;
            busy_o      <= 1'b0;
            cpu_rst_n_o <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prgrom_upg_ctrl.sv
// Bench for prgrom_upg_ctrl: random images, stream-level reference model, write scoreboard.
module tb_prgrom_upg_ctrl;
  localparam int AW  = 4;
  localparam int TMO = 100;
`ifdef LOAD_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          prog_req = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          upg_rst, upg_wen, upg_done, cpu_rst_n, busy, err;
  logic [AW-1:0] upg_adr;
  logic [31:0]   upg_dat;
  logic [2:0]    state;

  int checks = 0;
  int errors = 0;
  logic [AW+31:0] exp_q[$];
  logic [31:0]    img_q[$];
  logic           wen_prev = 1'b0;

  prgrom_upg_ctrl #(.ADDR_W(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk), .rst_n(rst_n), .prog_req_i(prog_req), .rx_valid_i(rx_valid),
    .rx_data_i(rx_data), .upg_rst_o(upg_rst), .upg_wen_o(upg_wen), .upg_adr_o(upg_adr),
    .upg_dat_o(upg_dat), .upg_done_o(upg_done), .cpu_rst_n_o(cpu_rst_n), .busy_o(busy),
    .err_o(err), .state_o(state)
  );

  // Clock
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=running req=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s act=%0h req=%0h", name, act, req);
    end
  endtask

  // Scoreboard monitor: every ROM write must match the head of the expected queue.
  task automatic monitor();
    logic [AW+31:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        wen_prev = 1'b0;
      end else begin
        if (upg_wen) begin
          chk("wen_single_cycle", {63'd0, wen_prev}, 64'd0);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write act=%0h/%0h req=none", upg_adr, upg_dat);
          end else begin
            e = exp_q.pop_front();
            chk("rom_write", {28'd0, upg_adr, upg_dat}, {28'd0, e});
          end
        end
        wen_prev = upg_wen;
      end
    end
  endtask

  // Drivers (inputs change on the falling edge)
  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    if (gap > 0) begin
      rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic pulse_prog();
    prog_req = 1'b1;
    @(negedge clk);
    prog_req = 1'b0;
  endtask

  // Reference model: stream of header + img_q words (+ XOR byte), expected writes and outcome.
  task automatic load(input logic [15:0] n, input int gap_max, input bit bad_chk,
                      input bit poke, input bit do_prog);
    logic [7:0]  x;
    logic [31:0] w;
    logic [AW-1:0] a;
    bit ok, exp_err;
    x = 8'h00;
    ok = (n != 16'd0) && (32'(n) <= 2 ** AW);
    exp_err = !ok || (CHK_EN && bad_chk);
    if (do_prog) begin
      pulse_prog();
      chk("entry_status", {59'd0, upg_done, err, cpu_rst_n, busy, upg_rst}, 64'b00010);
    end
    send_byte(n[7:0], $urandom_range(0, gap_max));
    send_byte(n[15:8], ok ? $urandom_range(0, gap_max) : 0);
    if (!ok) begin
      rx_valid = 1'b0;
      chk("err_after_header", {63'd0, err}, 64'd1);
    end else begin
      for (int i = 0; i < int'(n); i++) begin
        w = img_q[i];
        a = AW'(i);
        exp_q.push_back({a, w});
        for (int b = 0; b < 4; b++) begin
          x ^= w[8*b +: 8];
          if (poke && i == 0 && b == 1) prog_req = 1'b1;
          send_byte(w[8*b +: 8], $urandom_range(0, gap_max));
          prog_req = 1'b0;
        end
      end
      if (CHK_EN) send_byte(bad_chk ? (x ^ 8'h01) : x, 0);
      rx_valid = 1'b0;
    end
    for (int k = 0; k < 20 && !(upg_done || err); k++) @(negedge clk);
    chk("load_end_seen", {63'd0, upg_done | err}, 64'd1);
    chk("end_status", {59'd0, upg_done, err, cpu_rst_n, busy, upg_rst},
        exp_err ? 64'b01001 : 64'b10100);
    chk("pending_writes", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    fork monitor(); join_none
    // Reset
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {58'd0, upg_rst, upg_wen, upg_done, cpu_rst_n, busy, err}, 64'b100100);
    chk("rst_adr", 64'(upg_adr), 64'd0);
    chk("rst_dat", 64'(upg_dat), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic load
    img_q = '{32'h12345678, 32'hDEADBEEF};
    load(16'd2, 1, 1'b0, 1'b0, 1'b1);

    // Zero count
    load(16'd0, 1, 1'b0, 1'b0, 1'b1);

    // Back-to-back bytes, including during WRITE cycles
    img_q = {};
    for (int i = 0; i < 4; i++) img_q.push_back($urandom);
    load(16'd4, 0, 1'b0, 1'b0, 1'b1);

    // Count bound: 2^AW accepted, 2^AW+1 rejected
    img_q = {};
    for (int i = 0; i < 16; i++) img_q.push_back($urandom);
    load(16'd16, 2, 1'b0, 1'b0, 1'b1);
    load(16'd17, 2, 1'b0, 1'b0, 1'b1);

    // Timeout after a data byte, then restart
    pulse_prog();
    send_byte(8'h02, 1);
    send_byte(8'h00, 2);
    send_byte(8'hAA, 0);
    rx_valid = 1'b0;
    repeat (TMO - 1) @(negedge clk);
    chk("tmo_not_yet", {63'd0, err}, 64'd0);
    @(negedge clk);
    chk("tmo_err", {59'd0, upg_done, err, cpu_rst_n, busy, upg_rst}, 64'b01001);
    pulse_prog();
    chk("restart_status", {59'd0, upg_done, err, cpu_rst_n, busy, upg_rst}, 64'b00010);
    img_q = '{32'hCAFEF00D, 32'h0BADC0DE};
    load(16'd2, 2, 1'b0, 1'b0, 1'b0);

    // Random loads, some with a stray prog_req during DATA
    repeat (5) begin
      int n;
      n = $urandom_range(1, 6);
      img_q = {};
      for (int i = 0; i < n; i++) img_q.push_back($urandom);
      load(16'(n), $urandom_range(0, 3), 1'b0, 1'($urandom_range(0, 1)), 1'b1);
    end

`ifdef LOAD_CHECKSUM_EN
    img_q = '{32'h08040201};
    load(16'd1, 1, 1'b0, 1'b0, 1'b1);
    load(16'd1, 1, 1'b1, 1'b0, 1'b1);
`endif

    // Reset mid-load after 5 data bytes: word 0 already written
    img_q = '{32'h11223344, 32'h55667788};
    pulse_prog();
    send_byte(8'h02, 0);
    send_byte(8'h00, 1);
    exp_q.push_back({AW'(0), img_q[0]});
    for (int b = 0; b < 4; b++) send_byte(img_q[0][8*b +: 8], 0);
    send_byte(img_q[1][7:0], 0);
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midload_rst", {58'd0, upg_done, err, cpu_rst_n, busy, upg_rst, upg_wen}, 64'b001010);
    chk("midload_writes", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prgrom_upg_ctrl.md
Name: prgrom_upg_ctrl

Overview:
- Sequences UART reprogramming of the instruction ROM and arbitrates ROM ownership between CPU fetch and loader.
- Consumes a byte stream from the UART receiver, assembles 32-bit little-endian words and drives the ROM upgrade port (upg_rst/upg_wen/upg_adr/upg_dat/upg_done).
- Holds the CPU in reset while an image is loading.

Parameters:
ADDR_W, 14, word-address width of the program ROM
TIMEOUT_CYCLES, 1000000, idle clk cycles between bytes before a load aborts

Ports:
clk  in  1  system clock; all state updates on rising edge
rst_n  in  1  reset, asynchronous, active-low
prog_req  in  1  start-load request, single-cycle pulse, debounced upstream
rx_valid  in  1  one-cycle strobe, rx_data valid
rx_data  in  8  received byte
upg_rst  out  1  1 = ROM owned by CPU fetch; 0 = loader owns ROM
upg_wen  out  1  ROM write enable, one cycle per word
upg_adr  out  ADDR_W  ROM word address
upg_dat  out  32  ROM write data
upg_done  out  1  image complete; ROM returned to CPU
cpu_rst_n  out  1  CPU reset, active-low
busy  out  1  load in progress
err  out  1  last load aborted

Behaviour:
- Reset (async): state IDLE; upg_rst=1, upg_wen=0, upg_adr=0, upg_dat=0, upg_done=0, cpu_rst_n=1, busy=0, err=0. A reset mid-load leaves partial ROM contents and releases the CPU.
- Outputs are registered. The stream is 2 header bytes (word count N, LSB first), then 4*N data bytes, each word LSB first.
- IDLE: the CPU runs. prog_req=1 -> HDR0 on the next edge. That edge also sets upg_rst=0, cpu_rst_n=0, busy=1, err=0 and upg_done=0.
- HDR0: rx_valid captures N[7:0] -> HDR1.
- HDR1: rx_valid captures N[15:8].
  - N==0 or N > 2^ADDR_W -> ERR.
  - Otherwise -> DATA, with byte_idx=0 and word_idx=0.
- DATA: rx_valid stores the byte into assembly buffer lane byte_idx, then byte_idx++.
  - On the 4th byte -> WRITE. The same edge loads upg_dat from the completed word and sets upg_adr=word_idx.
- WRITE: exactly one cycle, upg_wen=1.
  - The next edge drops upg_wen and increments word_idx.
  - A byte arriving during WRITE is captured as byte 0 of the next word (the assembly buffer is separate from upg_dat).
  - If word_idx==N-1 -> DONE; else -> DATA.
- DONE: upg_done=1, upg_rst=0, cpu_rst_n=1, busy=0. upg_adr and upg_dat hold their last values.
- ERR: err=1, upg_rst=1, upg_done=0, busy=0, cpu_rst_n=0 (CPU stays held because the image is partial).
- Restart: prog_req in DONE or ERR -> HDR0 with the same entry actions as from IDLE.
- prog_req is ignored in HDR0, HDR1, DATA and WRITE.
- rx_valid is ignored in IDLE, DONE and ERR.
- Timeout: the counter clears on state entry and on every rx_valid, and runs in HDR0/HDR1/DATA. Reaching TIMEOUT_CYCLES-1 without a byte -> ERR.
- upg_adr never wraps. The N bound guarantees word_idx <= 2^ADDR_W-1.

Optional Feature:
- Macro: LOAD_CHECKSUM_EN.
- Defined: after the last WRITE the FSM enters CHK instead of DONE.
  - CHK expects one byte equal to the XOR of all 4*N data bytes (header excluded).
  - Match -> DONE. Mismatch -> ERR. Timeout applies in CHK.
  - Words are already written before the check completes.
- Undefined: no CHK state and no XOR accumulator; the last WRITE goes directly to DONE.

Test Plan:
- Basic load: prog_req, then bytes 02 00 78 56 34 12 EF BE AD DE.
  - Expect a write of 0x12345678 at adr 0 and 0xDEADBEEF at adr 1, each with upg_wen high for exactly 1 cycle.
  - Then upg_done=1, cpu_rst_n=1, busy=0.
- Zero count: prog_req, bytes 00 00 -> err=1 one edge after the 2nd byte, no upg_wen pulse, cpu_rst_n=0.
- Back-to-back bytes: 4-word image with rx_valid high every cycle, including during WRITE cycles -> all 4 words correct at adr 0..3, no byte lost.
- Timeout: TIMEOUT_CYCLES=100; send 02 00 AA, then silence -> err=1 at 100 cycles after the AA byte; a later prog_req clears err and restarts at HDR0.
- Reset mid-load: assert rst_n=0 after 5 data bytes -> upg_rst=1, cpu_rst_n=1, busy=0 immediately (async), word 0 remains written.
- LOAD_CHECKSUM_EN: 01 00 01 02 04 08 then 0F -> DONE; same image with checksum 0E -> err=1, with word 0x08040201 still written at adr 0.
